// File: rtl/pc_sequencer_if.sv
//------------------------------------------------------------------------------
// pc_sequencer_if : decode/fetch-side bus of the program-counter sequencer.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if #(
  parameter int AW    = 12,
  parameter int DW    = 8,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           en_i;
  logic [3:0]     op_i;
  logic           zero_i;
  logic           carry_i;
  logic [DW-1:0]  disp_i;
  logic [AW-1:0]  jump_i;
  logic           irq_i;
  logic [AW-1:0]  int_vec_i;
  logic [AW-1:0]  pc_o;
  logic           int_ack_o;
  logic           ie_o;
  logic           in_isr_o;
  logic [SPW-1:0] sp_o;
  logic [1:0]     fault_o;

  modport master (
    output en_i, op_i, zero_i, carry_i, disp_i, jump_i, irq_i, int_vec_i,
    input  pc_o, int_ack_o, ie_o, in_isr_o, sp_o, fault_o
  );

  modport slave (
    input  en_i, op_i, zero_i, carry_i, disp_i, jump_i, irq_i, int_vec_i,
    output pc_o, int_ack_o, ie_o, in_isr_o, sp_o, fault_o
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// pc_sequencer : registered PC with branches, call/return stack and interrupts.
// Optional macro PC_SEQUENCER_NESTED_INT_EN enables nested interrupt levels.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter int          AW       = 12,
  parameter int          DW       = 8,
  parameter int          DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  pc_sequencer_if.slave bus
);
  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_ISR  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ie_q, ie_d;
  logic           ack_q, ack_d;
  logic [1:0]     fault_q, fault_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic           push_en;
  logic [AW-1:0]  push_val;

  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  pc_tgt;
  logic [SPW-1:0] sp_dec;
  logic [AW-1:0]  stack_top;
  logic           stack_full;
  logic           stack_empty;
  logic           cond_met;
  logic           irq_ok;
  logic           irq_state_ok;

  assign pc_inc      = pc_q + 1'b1;
  assign pc_tgt      = pc_q + {{(AW-DW){bus.disp_i[DW-1]}}, bus.disp_i};
  assign sp_dec      = sp_q - 1'b1;
  assign stack_top   = stack_q[sp_dec[PW-1:0]];
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);

  always_comb begin
    cond_met = 1'b0;
    case (bus.op_i[1:0])
      2'b00:   cond_met = bus.zero_i;
      2'b01:   cond_met = !bus.zero_i;
      2'b10:   cond_met = bus.carry_i;
      default: cond_met = !bus.carry_i;
    endcase
  end

`ifdef PC_SEQUENCER_NESTED_INT_EN
  logic [SPW-1:0] nest_q, nest_d;
  assign irq_state_ok = (state_q == S_RUN) || (state_q == S_ISR);
  assign bus.in_isr_o = (nest_q != '0);
`else
  assign irq_state_ok = (state_q == S_RUN);
  assign bus.in_isr_o = (state_q == S_ISR);
`endif

  // A full stack defers the interrupt rather than faulting.
  assign irq_ok = bus.irq_i && ie_q && !stack_full && irq_state_ok;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    ie_d     = ie_q;
    ack_d    = 1'b0;
    fault_d  = fault_q;
    push_en  = 1'b0;
    push_val = pc_inc;
`ifdef PC_SEQUENCER_NESTED_INT_EN
    nest_d   = nest_q;
`endif
    if (bus.en_i && (state_q != S_HALT)) begin
      if (irq_ok) begin
        push_en  = 1'b1;
        push_val = pc_q;
        sp_d     = sp_q + 1'b1;
        pc_d     = bus.int_vec_i;
        ie_d     = 1'b0;
        ack_d    = 1'b1;
        state_d  = S_ISR;
`ifdef PC_SEQUENCER_NESTED_INT_EN
        nest_d   = nest_q + 1'b1;
`endif
      end else begin
        casez (bus.op_i)
          4'b00??: pc_d = cond_met ? pc_tgt : pc_inc;
          4'b0101: pc_d = pc_tgt;
          4'b0110: begin
            if (stack_full) begin
              fault_d[0] = 1'b1;
              state_d    = S_HALT;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
              pc_d    = bus.jump_i;
            end
          end
          4'b0111, 4'b1001: begin
            if (stack_empty) begin
              fault_d[1] = 1'b1;
              state_d    = S_HALT;
            end else begin
              pc_d = stack_top;
              sp_d = sp_dec;
              if (bus.op_i[3]) begin
                ie_d = 1'b1;
`ifdef PC_SEQUENCER_NESTED_INT_EN
                if (nest_q != '0) nest_d = nest_q - 1'b1;
                state_d = (nest_q > SPW'(1)) ? S_ISR : S_RUN;
`else
                state_d = S_RUN;
`endif
              end
            end
          end
          4'b1000: pc_d = bus.jump_i;
          4'b1010: begin
            ie_d = 1'b1;
            pc_d = pc_inc;
          end
          4'b1011: begin
            ie_d = 1'b0;
            pc_d = pc_inc;
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      ie_q    <= 1'b0;
      ack_q   <= 1'b0;
      fault_q <= 2'b00;
`ifdef PC_SEQUENCER_NESTED_INT_EN
      nest_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ie_q    <= ie_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
`ifdef PC_SEQUENCER_NESTED_INT_EN
      nest_q  <= nest_d;
`endif
    end
  end

  // Stack storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_en) stack_q[sp_q[PW-1:0]] <= push_val;
  end

  assign bus.pc_o      = pc_q;
  assign bus.int_ack_o = ack_q;
  assign bus.ie_o      = ie_q;
  assign bus.sp_o      = sp_q;
  assign bus.fault_o   = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// tb_pc_sequencer : scoreboard bench for pc_sequencer with default parameters.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  localparam logic [3:0] OP_BZ   = 4'b0000;
  localparam logic [3:0] OP_BNZ  = 4'b0001;
  localparam logic [3:0] OP_BC   = 4'b0010;
  localparam logic [3:0] OP_BNC  = 4'b0011;
  localparam logic [3:0] OP_INC  = 4'b0100;
  localparam logic [3:0] OP_BRA  = 4'b0101;
  localparam logic [3:0] OP_CALL = 4'b0110;
  localparam logic [3:0] OP_RET  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_RETI = 4'b1001;
  localparam logic [3:0] OP_EI   = 4'b1010;
  localparam logic [3:0] OP_DI   = 4'b1011;
  localparam logic [3:0] OP_RSV  = 4'b1100;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        ie;
    logic        isr;
    logic        ack;
    logic [1:0]  fault;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  pc_sequencer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  pc_sequencer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input logic [11:0] pc, input logic [3:0] sp, input logic ie,
                              input logic isr, input logic ack, input logic [1:0] fault);
    exp_t e;
    e.pc = pc; e.sp = sp; e.ie = ie; e.isr = isr; e.ack = ack; e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic compare_state(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, ".pc"},    32'(bus.pc_o),      32'(e.pc));
      check_val({tag, ".sp"},    32'(bus.sp_o),      32'(e.sp));
      check_val({tag, ".ie"},    32'(bus.ie_o),      32'(e.ie));
      check_val({tag, ".isr"},   32'(bus.in_isr_o),  32'(e.isr));
      check_val({tag, ".ack"},   32'(bus.int_ack_o), 32'(e.ack));
      check_val({tag, ".fault"}, 32'(bus.fault_o),   32'(e.fault));
    end
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    bus.en_i = 1'b1; bus.op_i = OP_JMP; bus.jump_i = 12'h777; bus.irq_i = 1'b1;
    expect_state(12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge clk_i); #1;
    compare_state(tag);
    rst_i = 1'b0;
    bus.irq_i = 1'b0;
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [11:0] jmp,
                      input logic [7:0] disp, input logic z, input logic c, input logic irq,
                      input logic en, input logic [11:0] e_pc, input logic [3:0] e_sp,
                      input logic e_ie, input logic e_isr, input logic e_ack,
                      input logic [1:0] e_fault);
    bus.op_i = op; bus.jump_i = jmp; bus.disp_i = disp; bus.zero_i = z;
    bus.carry_i = c; bus.irq_i = irq; bus.en_i = en;
    expect_state(e_pc, e_sp, e_ie, e_isr, e_ack, e_fault);
    @(posedge clk_i); #1;
    compare_state(tag);
  endtask

  initial begin
    bus.en_i = 1'b1; bus.op_i = OP_INC; bus.zero_i = 1'b0; bus.carry_i = 1'b0;
    bus.disp_i = '0; bus.jump_i = '0; bus.irq_i = 1'b0; bus.int_vec_i = 12'h080;
    @(posedge clk_i); #1;
    do_reset("rst0");

    step("inc1", OP_INC, 0, 0, 0, 0, 0, 1, 12'h001, 0, 0, 0, 0, 2'b00);
    step("inc2", OP_INC, 0, 0, 0, 0, 0, 1, 12'h002, 0, 0, 0, 0, 2'b00);
    step("inc3", OP_INC, 0, 0, 0, 0, 0, 1, 12'h003, 0, 0, 0, 0, 2'b00);

    // Branch conditions and wrap-around
    step("jmp10",  OP_JMP, 12'h010, 0, 0, 0, 0, 1, 12'h010, 0, 0, 0, 0, 2'b00);
    step("bz_t",   OP_BZ,  0, 8'hFC, 1, 0, 0, 1, 12'h00C, 0, 0, 0, 0, 2'b00);
    step("jmp10b", OP_JMP, 12'h010, 0, 0, 0, 0, 1, 12'h010, 0, 0, 0, 0, 2'b00);
    step("bz_nt",  OP_BZ,  0, 8'hFC, 0, 0, 0, 1, 12'h011, 0, 0, 0, 0, 2'b00);
    step("bnz_t",  OP_BNZ, 0, 8'h04, 0, 0, 0, 1, 12'h015, 0, 0, 0, 0, 2'b00);
    step("bc_t",   OP_BC,  0, 8'h10, 0, 1, 0, 1, 12'h025, 0, 0, 0, 0, 2'b00);
    step("bnc_nt", OP_BNC, 0, 8'h10, 0, 1, 0, 1, 12'h026, 0, 0, 0, 0, 2'b00);
    step("bra_neg",OP_BRA, 0, 8'h80, 0, 0, 0, 1, 12'hFA6, 0, 0, 0, 0, 2'b00);
    step("jmpfff", OP_JMP, 12'hFFF, 0, 0, 0, 0, 1, 12'hFFF, 0, 0, 0, 0, 2'b00);
    step("wrap",   OP_INC, 0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0, 2'b00);
    step("rsvd",   OP_RSV, 12'h555, 8'h40, 1, 1, 0, 1, 12'h001, 0, 0, 0, 0, 2'b00);

    // Call / return
    step("jmp20", OP_JMP,  12'h020, 0, 0, 0, 0, 1, 12'h020, 0, 0, 0, 0, 2'b00);
    step("call",  OP_CALL, 12'h300, 0, 0, 0, 0, 1, 12'h300, 1, 0, 0, 0, 2'b00);
    step("ret",   OP_RET,  0, 0, 0, 0, 0, 1, 12'h021, 0, 0, 0, 0, 2'b00);

    // Interrupt entry replaces the op; RETI resumes at the interrupted PC
    step("jmp5",  OP_JMP,  12'h005, 0, 0, 0, 0, 1, 12'h005, 0, 0, 0, 0, 2'b00);
    step("ei",    OP_EI,   0, 0, 0, 0, 0, 1, 12'h006, 0, 1, 0, 0, 2'b00);
    step("irq",   OP_CALL, 12'h300, 0, 0, 0, 1, 1, 12'h080, 1, 0, 1, 1, 2'b00);
    step("isr1",  OP_INC,  0, 0, 0, 0, 1, 1, 12'h081, 1, 0, 1, 0, 2'b00);
    step("reti",  OP_RETI, 0, 0, 0, 0, 0, 1, 12'h006, 0, 1, 0, 0, 2'b00);
    step("stall", OP_JMP,  12'h123, 0, 0, 0, 1, 0, 12'h006, 0, 1, 0, 0, 2'b00);

    // Fill the stack; a pending interrupt must be deferred, then overflow halts
    for (int i = 0; i < DEPTH; i++) begin
      step($sformatf("fill%0d", i), OP_CALL, 12'h100 + 12'(i), 0, 0, 0, 0, 1,
           12'h100 + 12'(i), 4'(i + 1), 1, 0, 0, 2'b00);
    end
    step("defer", OP_INC,  0, 0, 0, 0, 1, 1, 12'h108, 8, 1, 0, 0, 2'b00);
    step("ovf",   OP_CALL, 12'h200, 0, 0, 0, 0, 1, 12'h108, 8, 1, 0, 0, 2'b01);
    step("halt1", OP_JMP,  12'h333, 0, 0, 0, 0, 1, 12'h108, 8, 1, 0, 0, 2'b01);
    step("halt2", OP_RET,  0, 0, 0, 0, 1, 1, 12'h108, 8, 1, 0, 0, 2'b01);
    do_reset("rst1");

    // Underflow, reset recovery and stall
    step("unf",   OP_RET,  0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0, 2'b10);
    step("halt3", OP_JMP,  12'h123, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0, 2'b10);
    do_reset("rst2");
    step("stall2",OP_JMP,  12'h123, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 2'b00);
    step("jmp123",OP_JMP,  12'h123, 0, 0, 0, 0, 1, 12'h123, 0, 0, 0, 0, 2'b00);

    // RETI outside an ISR pops and enables interrupts
    step("call50",OP_CALL, 12'h050, 0, 0, 0, 0, 1, 12'h050, 1, 0, 0, 0, 2'b00);
    step("di",    OP_DI,   0, 0, 0, 0, 0, 1, 12'h051, 1, 0, 0, 0, 2'b00);
    step("reti2", OP_RETI, 0, 0, 0, 0, 0, 1, 12'h124, 0, 1, 0, 0, 2'b00);

    // Reset while inside an ISR
    step("irq2",  OP_INC,  0, 0, 0, 0, 1, 1, 12'h080, 1, 0, 1, 1, 2'b00);
    do_reset("rst3");
    step("post",  OP_INC,  0, 0, 0, 0, 0, 1, 12'h001, 0, 0, 0, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
